fetch_unit: RTL and testbench

Instruction fetch stage for the ARM core. It owns the fetch PC and issues word reads to instruction memory over a request/grant/response handshake. Returned words go into a small in-order buffer. It presents one instruction per cycle, with its PC and pre-sliced decode fields, to the decode stage over a valid/ready handshake. Branch and PC-write redirects from execute flush the buffer and discard stale in-flight responses.

---
 rtl/fetch_if.sv | 44 ++++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response,
// redirect from execute, and the valid/ready instruction path to decode.
interface fetch_if;
    // Instruction memory request/grant/response
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Redirect from execute
    logic        redirect;
    logic [31:0] redirect_pc;

    // Instruction path to decode
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  instr74;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr, instr_pc, op, funct, rd, instr74
    );

    // Memory / pipeline side
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr, instr_pc, op, funct, rd, instr74
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads with a
// credit limit of DEPTH, buffers returned words in order with their PCs and
// hands them to decode. A redirect flushes the buffer and arms a drop count
// so responses still in flight for the old stream are discarded.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    rst_n,
    fetch_if.master bus
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);

    // Fetch PC and credit state
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;

    // Per-request PC tags, in grant order
    logic [31:0]   r_tag [DEPTH];
    logic [PW-1:0] r_tag_wr;
    logic [PW-1:0] r_tag_rd;

    // Instruction buffer
    logic [31:0]   r_word [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_req;
    logic          w_grant;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_occupancy;
    logic [CW-1:0] w_inflight_nxt;
    logic [31:0]   w_instr;
    logic [1:0]    w_unused_pc_lsbs;

    // Requests are throttled on registered state only, so outstanding
    // requests plus buffered words can never exceed the buffer size.
    assign w_occupancy    = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_req          = rst_n & (w_occupancy < {1'b0, C_DEPTH});
    assign w_grant        = w_req & bus.imem_gnt;
    // A response with no credit outstanding is a protocol error and is ignored.
    assign w_rsp          = bus.imem_rvalid & (r_inflight != '0);
    assign w_push         = w_rsp & (r_drop == '0) & ~bus.redirect;
    assign w_pop          = (r_count != '0) & bus.instr_ready & ~bus.redirect;
    assign w_inflight_nxt = r_inflight + CW'(w_grant) - CW'(w_rsp);

    // Redirect targets are word aligned; the low bits carry no information.
    assign w_unused_pc_lsbs = bus.redirect_pc[1:0];

    // Fetch PC, in-flight credit and drop count.
    // NOTE: sequential state is written with <= so every register in the
    // design updates from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (bus.redirect) begin
                // Every response still outstanding after this edge belongs to
                // the old stream, including a request granted at this edge.
                r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                r_drop     <= w_inflight_nxt;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - C_ONE;
                end
            end
        end
    end

    // Tag pointers: one entry per granted request, retired by its response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else begin
            if (w_grant) begin
                r_tag_wr <= r_tag_wr + P_ONE;
            end
            if (w_rsp) begin
                r_tag_rd <= r_tag_rd + P_ONE;
            end
        end
    end

    // Tag storage: capture the PC of each granted request.
    // NOTE: this array has no reset; an entry is only read after its own
    // grant has written it, so resetting it would buy nothing.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_tag[r_tag_wr] <= r_fetch_pc;
        end
    end

    // Instruction buffer: push returned words, pop to decode, flush on redirect.
    // Storage is reset so instr/instr_pc come up as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_word[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (bus.redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_word[r_wr_ptr] <= bus.imem_rdata;
                r_pc[r_wr_ptr]   <= r_tag[r_tag_rd];
                r_wr_ptr         <= r_wr_ptr + P_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + P_ONE;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign w_instr         = r_word[r_rd_ptr];

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = (r_count != '0);
    assign bus.instr       = w_instr;
    assign bus.instr_pc    = r_pc[r_rd_ptr];
    assign bus.op          = w_instr[27:26];
    assign bus.funct       = w_instr[25:20];
    assign bus.rd          = w_instr[15:12];
    assign bus.instr74     = w_instr[7:4];

    a_rsp_has_credit: assert property (
        @(posedge clk) disable iff (!rst_n) bus.imem_rvalid |-> (r_inflight != '0)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a fixed-latency memory model returning the
// address as data, with hand-computed expected PCs, words and cycle timing.
module tb_fetch_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model configuration: response stage index (latency - 1) and
    // whether PC 8 returns the special decode-test word.
    logic [1:0] lat_idx = 2'd0;
    bit         special = 1'b0;

    logic        pv [3];
    logic [31:0] pa [3];

    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Fixed-latency in-order memory: a grant enters a short delay line and
    // comes back as a response lat_idx+1 cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
            end
        end else begin
            pv[0] <= bus.imem_req & bus.imem_gnt;
            pa[0] <= bus.imem_addr;
            for (int i = 1; i < 3; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign bus.imem_rvalid = pv[lat_idx];
    assign bus.imem_rdata  = (special && (pa[lat_idx] == 32'h8)) ? 32'hE3A0_F00C : pa[lat_idx];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset, check reset state, release at a falling edge; the caller
    // is then in cycle 1, the first cycle after release.
    task automatic apply_reset(input logic [1:0] lat_sel, input bit sp);
        rst_n = 1'b0;
        #1;
        lat_idx = lat_sel;
        special = sp;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",      32'(bus.imem_req),    32'd0);
        check("rst_valid",    32'(bus.instr_valid), 32'd0);
        check("rst_addr",     bus.imem_addr,        32'h0);
        check("rst_instr",    bus.instr,            32'h0);
        check("rst_instr_pc", bus.instr_pc,         32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_req",  32'(bus.imem_req), 32'd1);
        check("rel_addr", bus.imem_addr,     32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;

        bus.imem_gnt    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b1;

        // Streaming with 1-cycle memory: first valid in cycle 3, then one per cycle.
        apply_reset(2'd0, 1'b0);
        check("t1_c1_valid", 32'(bus.instr_valid), 32'd0);
        step();
        check("t1_c2_valid", 32'(bus.instr_valid), 32'd0);
        check("t1_c2_addr",  bus.imem_addr,        32'h4);
        for (int k = 0; k < 8; k++) begin
            step();
            check("t1_valid", 32'(bus.instr_valid), 32'd1);
            check("t1_pc",    bus.instr_pc,         32'(4 * k));
            check("t1_instr", bus.instr,            32'(4 * k));
        end

        // Back-pressure: buffer fills with PCs 0..C, requests stop, head holds.
        bus.instr_ready = 1'b0;
        apply_reset(2'd0, 1'b0);
        repeat (10) step();
        check("t2_full_req",   32'(bus.imem_req),    32'd0);
        check("t2_full_valid", 32'(bus.instr_valid), 32'd1);
        check("t2_full_pc",    bus.instr_pc,         32'h0);
        check("t2_full_addr",  bus.imem_addr,        32'h10);
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t2_valid", 32'(bus.instr_valid), 32'd1);
            check("t2_pc",    bus.instr_pc,         32'(4 * k));
            step();
        end

        // Redirect to 0x100 at the edge ending cycle 3, three old requests in
        // flight with 3-cycle memory; first new word valid in cycle 8.
        apply_reset(2'd2, 1'b0);
        step();
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect    = 1'b0;
        check("t3_addr",  bus.imem_addr,        32'h100);
        check("t3_valid", 32'(bus.instr_valid), 32'd0);
        waited = 0;
        while (!bus.instr_valid && waited < 20) begin
            step();
            waited++;
        end
        check("t3_wait", 32'(waited), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("t3_valid_seq", 32'(bus.instr_valid), 32'd1);
            check("t3_pc",        bus.instr_pc,         32'h100 + 32'(4 * k));
            check("t3_instr",     bus.instr,            32'h100 + 32'(4 * k));
            step();
        end

        // Redirect to 0x203 coinciding with a grant (PC 4) and a response (PC 0).
        apply_reset(2'd0, 1'b0);
        step();
        check("t4_c2_req",  32'(bus.imem_req), 32'd1);
        check("t4_c2_addr", bus.imem_addr,     32'h4);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h203;
        step();
        bus.redirect    = 1'b0;
        check("t4_c3_addr",  bus.imem_addr,        32'h200);
        check("t4_c3_valid", 32'(bus.instr_valid), 32'd0);
        step();
        check("t4_c4_valid", 32'(bus.instr_valid), 32'd0);
        step();
        check("t4_c5_valid", 32'(bus.instr_valid), 32'd1);
        check("t4_c5_pc",    bus.instr_pc,         32'h200);
        check("t4_c5_instr", bus.instr,            32'h200);
        step();
        check("t4_c6_pc",    bus.instr_pc,         32'h204);

        // Decode field slicing of 0xE3A0F00C at PC 8 (head in cycle 5).
        apply_reset(2'd0, 1'b1);
        repeat (4) step();
        check("t5_valid",   32'(bus.instr_valid), 32'd1);
        check("t5_pc",      bus.instr_pc,         32'h8);
        check("t5_instr",   bus.instr,            32'hE3A0_F00C);
        check("t5_op",      32'(bus.op),          32'h0);
        check("t5_funct",   32'(bus.funct),       32'h3A);
        check("t5_rd",      32'(bus.rd),          32'hF);
        check("t5_instr74", 32'(bus.instr74),     32'h0);
        step();
        check("t5_next_pc", bus.instr_pc,         32'hC);

        // Asynchronous reset pulse between edges mid-stream.
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(bus.instr_valid), 32'd0);
        check("t6_addr",  bus.imem_addr,        32'h0);
        check("t6_req",   32'(bus.imem_req),    32'd0);
        check("t6_instr", bus.instr,            32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check("t6_rel_req",  32'(bus.imem_req), 32'd1);
        check("t6_rel_addr", bus.imem_addr,     32'h0);
        step();
        check("t6_c2_valid", 32'(bus.instr_valid), 32'd0);
        step();
        check("t6_c3_valid", 32'(bus.instr_valid), 32'd1);
        check("t6_c3_pc",    bus.instr_pc,         32'h0);
        step();
        check("t6_c4_pc",    bus.instr_pc,         32'h4);
        check("t6_c4_instr", bus.instr,            32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
